// File: rtl/ex_hilo_muldiv.sv
// rtl/ex_hilo_muldiv.sv - E-stage multiply/divide unit owning the HI/LO registers
// Single-cycle MULT/MULTU/MTHI/MTLO; 32-iteration restoring DIV/DIVU with pipeline stall.
module ex_hilo_muldiv #(
    parameter logic [7:0] OP_MULT  = 8'h18,
    parameter logic [7:0] OP_MULTU = 8'h19,
    parameter logic [7:0] OP_DIV   = 8'h1A,
    parameter logic [7:0] OP_DIVU  = 8'h1B,
    parameter logic [7:0] OP_MTHI  = 8'h1C,
    parameter logic [7:0] OP_MTLO  = 8'h1D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        hilowriteE,
    input  logic [7:0]  ALUControlE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_div,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_t;

    divState_t state, stateNext;

    logic [4:0]  count;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        qNeg;
    logic        rNeg;

    logic        issue;
    logic        isDiv;
    logic        signedDiv;
    logic        divStart;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [63:0] prodS;
    logic [63:0] prodU;

    logic [32:0] remShift;
    logic        takeSub;
    logic [31:0] remStep;
    logic [31:0] quotStep;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;

    assign issue     = hilowriteE & ~flush & (state == IDLE);
    assign isDiv     = (ALUControlE == OP_DIV) || (ALUControlE == OP_DIVU);
    assign signedDiv = (ALUControlE == OP_DIV);
    assign divStart  = issue & isDiv & (srcbE != 32'd0);

    // Magnitudes for the unsigned core; |0x80000000| stays 0x80000000 as an unsigned value.
    assign absA = (signedDiv & srcaE[31]) ? (~srcaE + 32'd1) : srcaE;
    assign absB = (signedDiv & srcbE[31]) ? (~srcbE + 32'd1) : srcbE;

    assign prodS = {{32{srcaE[31]}}, srcaE} * {{32{srcbE[31]}}, srcbE};
    assign prodU = {32'd0, srcaE} * {32'd0, srcbE};

    // One restoring step: shift the next dividend bit into the partial remainder, try a subtract.
    always_comb begin
        remShift = {rem, quot[31]};
        takeSub  = (remShift >= {1'b0, divisor});
        remStep  = takeSub ? (remShift[31:0] - divisor) : remShift[31:0];
        quotStep = {quot[30:0], takeSub};
    end

    assign quotFinal = qNeg ? (~quotStep + 32'd1) : quotStep;
    assign remFinal  = rNeg ? (~remStep + 32'd1) : remStep;

    assign stall_div = ~reset & (divStart | ((state == RUN) & ~flush));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (divStart) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (count == 5'd31) begin
                    stateNext = DONE;
                end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            count   <= 5'd0;
            divisor <= 32'd0;
            quot    <= 32'd0;
            rem     <= 32'd0;
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        case (ALUControlE)
                            OP_MULT:  {hi, lo} <= prodS;
                            OP_MULTU: {hi, lo} <= prodU;
                            OP_MTHI:  hi <= srcaE;
                            OP_MTLO:  lo <= srcaE;
                            OP_DIV, OP_DIVU: begin
                                if (srcbE != 32'd0) begin
                                    divisor <= absB;
                                    quot    <= absA;
                                    rem     <= 32'd0;
                                    count   <= 5'd0;
                                    qNeg    <= signedDiv & (srcaE[31] ^ srcbE[31]);
                                    rNeg    <= signedDiv & srcaE[31];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // A flush aborts the divide and leaves HI/LO untouched.
                    if (!flush) begin
                        quot  <= quotStep;
                        rem   <= remStep;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            lo <= quotFinal;
                            hi <= remFinal;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ex_hilo_muldiv.md
Name: ex_hilo_muldiv

Overview:
Execute-stage multiply/divide unit owning the HI/LO architectural registers. It sits directly downstream of the ID/EX pipeline register and consumes its E-stage outputs (hilowriteE, ALUControlE, srcaE, and the resolved second operand). MULT/MULTU and MTHI/MTLO complete in one cycle. DIV/DIVU run a 32-iteration restoring divider, and the unit raises a stall to the hazard unit until the quotient and remainder are written.

Parameters:
OP_MULT, 8'h18, ALUControl code for signed multiply
OP_MULTU, 8'h19, ALUControl code for unsigned multiply
OP_DIV, 8'h1A, ALUControl code for signed divide
OP_DIVU, 8'h1B, ALUControl code for unsigned divide
OP_MTHI, 8'h1C, ALUControl code for move srca to HI
OP_MTLO, 8'h1D, ALUControl code for move srca to LO

Ports:
clk  input  1  clock; only clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  flush of the E-stage instruction (exception/branch recovery)
hilowriteE  input  1  E-stage instruction targets HI/LO; qualifies ALUControlE
ALUControlE  input  8  operation code
srcaE  input  32  operand A (rs), forwarded
srcbE  input  32  operand B (rt), forwarded
hi  output  32  HI register
lo  output  32  LO register
stall_div  output  1  stall request to hazard unit (freezes IF/ID/E and bubbles MEM)
busy  output  1  divider FSM not IDLE

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, iteration counter=0, divider datapath regs=0. Outputs stall_div=0 and busy=0 during and after reset.
- issue = hilowriteE & ~flush & state==IDLE. Codes other than the six listed are ignored, with no HI/LO change.
- MULT: {hi,lo} <= signed(srcaE)*signed(srcbE), 64-bit, written at the edge ending the issue cycle. MULTU uses the same timing with an unsigned product. No stall.
- MTHI: hi <= srcaE. MTLO: lo <= srcaE. One cycle; the other register is unchanged.
- DIV/DIVU with srcbE==0: no-op. HI/LO unchanged, no stall, FSM stays IDLE.
- DIV/DIVU with srcbE!=0, issue in cycle t:
  - stall_div=1 combinationally in cycle t.
  - Edge ending cycle t: latch |A| and |B| (or raw values for DIVU), quotient sign (sA^sB), and remainder sign (sA). Clear the partial remainder. counter=0. state -> RUN.
  - RUN: one restoring shift-subtract iteration per cycle, counter +1, stall_div=1.
  - At the edge ending the RUN cycle with counter==31, lo <= signed-corrected quotient and hi <= signed-corrected remainder. state -> DONE. HI/LO are visible from cycle t+33.
  - DONE: stall_div=0, so the pipeline advances the divide instruction. Inputs are ignored, so the held instruction is never re-issued. Unconditional return to IDLE next edge.
  - stall_div is high for exactly 33 cycles (t..t+32).
- Sign rules: quotient truncates toward zero and the remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0 (wrap, no trap).
- While in RUN or DONE, hilowriteE/ALUControlE/operands are ignored. Operands are taken only at issue.
- flush while in RUN: abort. state -> IDLE next edge, HI/LO unchanged, stall_div drops combinationally in that cycle.
- flush in IDLE suppresses issue for all ops.
- flush in DONE: HI/LO already written and not rolled back.
- Reset asserted mid-divide: immediate return to reset values.
- busy = (state!=IDLE).

Test Plan:
- Reset, then MULT srca=0xFFFFFFFD (-3), srcb=7 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFEB, stall_div never high. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU 100/7 issued at cycle t -> stall_div high in cycles t..t+32, low at t+33. From t+33: lo=14, hi=2. Instruction held constant during the stall is not re-executed.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- With hi=0x11, lo=0x22, DIV 5/0 -> no stall, hi/lo remain 0x11/0x22. MTHI 0xABCD then MTLO 0x1234 in back-to-back cycles -> hi=0xABCD, lo=0x1234.
- DIVU 1000/3 started, flush pulsed in the 10th RUN cycle -> stall_div drops that cycle, busy=0 next cycle, HI/LO unchanged, and a subsequent MTLO 5 works.
- Async reset asserted mid-divide -> hi=lo=0, stall_div=0, busy=0 immediately, without waiting for a clock edge.
